vx_opc_dep_sched: RTL and testbench

VX_OPC_DEP_SCHED -- requirements
Module: VX_opc_dep_sched

---
 rtl/vx_opc_dep_sched_pkg.sv | 20 ++
 rtl/vx_opc_dep_sched_if.sv | 43 ++++
 rtl/vx_opc_dep_sched_age_select.sv | 39 +++
 rtl/vx_opc_dep_sched.sv | 131 +++++++++++++
 tb/tb_vx_opc_dep_sched.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vx_opc_dep_sched_pkg.sv
// Shared constants and helpers for the operand-collector dependency scheduler.
// Memory-ordering modes are defined here so that every user of the block agrees on them.
package vx_opc_dep_sched_pkg;

  localparam int LSU_ORDER_NONE  = 0;
  localparam int LSU_ORDER_ALL   = 1;
  localparam int LSU_ORDER_STORE = 2;

  // Returns 1 when two memory ops must stay in program order under the given mode.
  function automatic logic lsu_conflict(input int mode,
                                        input logic a_lsu, input logic a_store,
                                        input logic b_lsu, input logic b_store);
    logic hit;
    hit = 1'b0;
    if (mode == LSU_ORDER_ALL)   hit = a_lsu && b_lsu;
    if (mode == LSU_ORDER_STORE) hit = a_lsu && b_lsu && (a_store || b_store);
    return hit;
  endfunction

endpackage

// File: rtl/vx_opc_dep_sched_if.sv
// Enqueue/dequeue/status bundle of the dependency scheduler.
// Enqueue is valid/ready: a transfer happens on a rising clk edge where enq_valid && enq_ready.
interface vx_opc_dep_sched_if #(
  parameter int NUM_OPCS = 4,
  parameter int NUM_SRCS = 3,
  parameter int NR_BITS  = 6,
  parameter int WIS_W    = 2
) ();
  localparam int OPC_W = $clog2(NUM_OPCS);

  logic                               enq_valid;
  logic                               enq_ready;
  logic [WIS_W-1:0]                   enq_wis;
  logic [NR_BITS-1:0]                 enq_rd;
  logic                               enq_used_rd;
  logic [NUM_SRCS-1:0][NR_BITS-1:0]   enq_rs;
  logic [NUM_SRCS-1:0]                enq_used_rs;
  logic                               enq_is_lsu;
  logic                               enq_is_store;
  logic [OPC_W-1:0]                   enq_opc;
  logic                               deq_valid;
  logic [OPC_W-1:0]                   deq_opc;
  logic [NUM_OPCS-1:0]                opc_busy;
  logic [NUM_OPCS-1:0][NUM_OPCS-1:0]  opc_wait_mask;
  logic [NUM_OPCS-1:0]                opc_ready;
  logic                               sel_valid;
  logic [OPC_W-1:0]                   sel_opc;
  logic                               full;

  modport master (
    output enq_valid, enq_wis, enq_rd, enq_used_rd, enq_rs, enq_used_rs,
           enq_is_lsu, enq_is_store, deq_valid, deq_opc,
    input  enq_ready, enq_opc, opc_busy, opc_wait_mask, opc_ready,
           sel_valid, sel_opc, full
  );

  modport slave (
    input  enq_valid, enq_wis, enq_rd, enq_used_rd, enq_rs, enq_used_rs,
           enq_is_lsu, enq_is_store, deq_valid, deq_opc,
    output enq_ready, enq_opc, opc_busy, opc_wait_mask, opc_ready,
           sel_valid, sel_opc, full
  );
endinterface

// File: rtl/vx_opc_dep_sched_age_select.sv
// Age matrix over the scheduler slots plus an oldest-ready pick.
// older_q[i][j] = 1 means slot j entered before slot i and both are still live.
module vx_opc_dep_sched_age_select #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         alloc_mask,
  input  logic [N-1:0]         free_mask,
  input  logic [N-1:0]         live_mask,
  input  logic [N-1:0]         ready_mask,
  output logic                 sel_valid,
  output logic [$clog2(N)-1:0] sel_idx
);
  logic [N-1:0] older_q [N];
  logic [N-1:0] pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc_mask[i])     older_q[i] <= live_mask;
        else if (free_mask[i]) older_q[i] <= '0;
        else                   older_q[i] <= older_q[i] & ~free_mask;
      end
    end
  end

  always_comb begin
    pick      = '0;
    sel_idx   = '0;
    for (int i = 0; i < N; i++)
      pick[i] = ready_mask[i] && ((older_q[i] & ready_mask) == '0);
    for (int i = N - 1; i >= 0; i--)
      if (pick[i]) sel_idx = ($clog2(N))'(i);
    sel_valid = |pick;
  end
endmodule

// File: rtl/vx_opc_dep_sched.sv
// Operand-collector dependency scheduler: tracks in-flight slots, builds per-slot
// wait rows (register hazards and memory ordering) and picks the oldest ready slot.
module vx_opc_dep_sched
  import vx_opc_dep_sched_pkg::*;
#(
  parameter int NUM_OPCS  = 4,
  parameter int NUM_SRCS  = 3,
  parameter int NR_BITS   = 6,
  parameter int WIS_W     = 2,
  parameter int LSU_ORDER = 1,
  parameter int RAW_CHECK = 0
) (
  input logic               clk,
  input logic               reset,
  vx_opc_dep_sched_if.slave bus
);
  localparam int OPC_W = $clog2(NUM_OPCS);

  logic [NUM_OPCS-1:0]              busy_q, used_rd_q, lsu_q, store_q;
  logic [NUM_OPCS-1:0]              wait_q [NUM_OPCS];
  logic [WIS_W-1:0]                 wis_q [NUM_OPCS];
  logic [NR_BITS-1:0]               rd_q [NUM_OPCS];
  logic [NUM_SRCS-1:0][NR_BITS-1:0] rs_q [NUM_OPCS];
  logic [NUM_SRCS-1:0]              used_rs_q [NUM_OPCS];

  logic                full, enq_fire, deq_fire;
  logic [OPC_W-1:0]    free_idx;
  logic [NUM_OPCS-1:0] deq_mask, alloc_mask, live_mask, new_row, ready;
  logic [NUM_OPCS-1:0] war_hit, waw_hit, raw_hit;

  always_comb begin
    free_idx   = '0;
    deq_mask   = '0;
    alloc_mask = '0;
    for (int i = NUM_OPCS - 1; i >= 0; i--)
      if (!busy_q[i]) free_idx = OPC_W'(i);
    full     = &busy_q;
    enq_fire = bus.enq_valid && !full;
    deq_fire = bus.deq_valid && busy_q[bus.deq_opc];
    if (deq_fire) deq_mask[bus.deq_opc] = 1'b1;
    if (enq_fire) alloc_mask[free_idx]  = 1'b1;
    // A slot retiring this cycle cannot hold up the newcomer.
    live_mask = busy_q & ~deq_mask;
  end

  always_comb begin
    war_hit = '0;
    waw_hit = '0;
    raw_hit = '0;
    new_row = '0;
    for (int j = 0; j < NUM_OPCS; j++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (bus.enq_used_rd && used_rs_q[j][s] && rs_q[j][s] == bus.enq_rd) war_hit[j] = 1'b1;
        if (bus.enq_used_rs[s] && used_rd_q[j] && rd_q[j] == bus.enq_rs[s]) raw_hit[j] = 1'b1;
      end
      waw_hit[j] = bus.enq_used_rd && used_rd_q[j] && rd_q[j] == bus.enq_rd;
      new_row[j] = live_mask[j] &&
                   (((wis_q[j] == bus.enq_wis) &&
                     (war_hit[j] || waw_hit[j] || (RAW_CHECK != 0 && raw_hit[j]))) ||
                    lsu_conflict(LSU_ORDER, lsu_q[j], store_q[j], bus.enq_is_lsu, bus.enq_is_store));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      used_rd_q <= '0;
      lsu_q     <= '0;
      store_q   <= '0;
      for (int i = 0; i < NUM_OPCS; i++) begin
        wait_q[i]    <= '0;
        wis_q[i]     <= '0;
        rd_q[i]      <= '0;
        rs_q[i]      <= '0;
        used_rs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OPCS; i++) begin
        if (deq_mask[i]) begin
          busy_q[i]    <= 1'b0;
          used_rd_q[i] <= 1'b0;
          lsu_q[i]     <= 1'b0;
          store_q[i]   <= 1'b0;
          wait_q[i]    <= '0;
          wis_q[i]     <= '0;
          rd_q[i]      <= '0;
          rs_q[i]      <= '0;
          used_rs_q[i] <= '0;
        end else if (alloc_mask[i]) begin
          busy_q[i]    <= 1'b1;
          used_rd_q[i] <= bus.enq_used_rd;
          lsu_q[i]     <= bus.enq_is_lsu;
          store_q[i]   <= bus.enq_is_store;
          wait_q[i]    <= new_row;
          wis_q[i]     <= bus.enq_wis;
          rd_q[i]      <= bus.enq_rd;
          rs_q[i]      <= bus.enq_rs;
          used_rs_q[i] <= bus.enq_used_rs;
        end else begin
          wait_q[i]    <= wait_q[i] & ~deq_mask;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OPCS; i++) begin
      ready[i]             = busy_q[i] && (wait_q[i] == '0);
      bus.opc_wait_mask[i] = wait_q[i];
    end
    bus.enq_ready = !full;
    bus.enq_opc   = free_idx;
    bus.opc_busy  = busy_q;
    bus.opc_ready = ready;
    bus.full      = full;
  end

  vx_opc_dep_sched_age_select #(.N(NUM_OPCS)) u_age (
    .clk        (clk),
    .reset      (reset),
    .alloc_mask (alloc_mask),
    .free_mask  (deq_mask),
    .live_mask  (live_mask),
    .ready_mask (ready),
    .sel_valid  (bus.sel_valid),
    .sel_idx    (bus.sel_opc)
  );

  deq_of_idle_slot: assert property (@(posedge clk) disable iff (reset)
    bus.deq_valid |-> busy_q[bus.deq_opc]);
endmodule

// File: tb/tb_vx_opc_dep_sched.sv
// Directed bench for vx_opc_dep_sched: instance a uses LSU_ORDER=1/RAW_CHECK=0,
// instance b uses LSU_ORDER=2/RAW_CHECK=1; both see identical stimulus.
module tb_vx_opc_dep_sched;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enq_valid = 1'b0;
  logic [1:0]       enq_wis = '0;
  logic [5:0]       enq_rd = '0;
  logic             enq_used_rd = 1'b0;
  logic [2:0][5:0]  enq_rs = '0;
  logic [2:0]       enq_used_rs = '0;
  logic             enq_is_lsu = 1'b0;
  logic             enq_is_store = 1'b0;
  logic             deq_valid = 1'b0;
  logic [1:0]       deq_opc = '0;
  int               tests = 0;
  int               fails = 0;

  vx_opc_dep_sched_if #(.NUM_OPCS(4), .NUM_SRCS(3), .NR_BITS(6), .WIS_W(2)) if_a ();
  vx_opc_dep_sched_if #(.NUM_OPCS(4), .NUM_SRCS(3), .NR_BITS(6), .WIS_W(2)) if_b ();

  assign if_a.enq_valid = enq_valid;     assign if_b.enq_valid = enq_valid;
  assign if_a.enq_wis = enq_wis;         assign if_b.enq_wis = enq_wis;
  assign if_a.enq_rd = enq_rd;           assign if_b.enq_rd = enq_rd;
  assign if_a.enq_used_rd = enq_used_rd; assign if_b.enq_used_rd = enq_used_rd;
  assign if_a.enq_rs = enq_rs;           assign if_b.enq_rs = enq_rs;
  assign if_a.enq_used_rs = enq_used_rs; assign if_b.enq_used_rs = enq_used_rs;
  assign if_a.enq_is_lsu = enq_is_lsu;   assign if_b.enq_is_lsu = enq_is_lsu;
  assign if_a.enq_is_store = enq_is_store; assign if_b.enq_is_store = enq_is_store;
  assign if_a.deq_valid = deq_valid;     assign if_b.deq_valid = deq_valid;
  assign if_a.deq_opc = deq_opc;         assign if_b.deq_opc = deq_opc;

  vx_opc_dep_sched #(.NUM_OPCS(4), .NUM_SRCS(3), .NR_BITS(6), .WIS_W(2),
                     .LSU_ORDER(1), .RAW_CHECK(0)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  vx_opc_dep_sched #(.NUM_OPCS(4), .NUM_SRCS(3), .NR_BITS(6), .WIS_W(2),
                     .LSU_ORDER(2), .RAW_CHECK(1)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enq_valid = 1'b0;
    deq_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // drivers
  task automatic set_enq(input logic [1:0] wis, input logic [5:0] rd, input logic urd,
                         input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                         input logic [2:0] urs, input logic lsu, input logic st);
    enq_valid    = 1'b1;
    enq_wis      = wis;
    enq_rd       = rd;
    enq_used_rd  = urd;
    enq_rs[0]    = r0;
    enq_rs[1]    = r1;
    enq_rs[2]    = r2;
    enq_used_rs  = urs;
    enq_is_lsu   = lsu;
    enq_is_store = st;
  endtask

  task automatic enq(input logic [1:0] wis, input logic [5:0] rd, input logic urd,
                     input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                     input logic [2:0] urs, input logic lsu, input logic st);
    set_enq(wis, rd, urd, r0, r1, r2, urs, lsu, st);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic deq(input logic [1:0] opc);
    deq_valid = 1'b1;
    deq_opc   = opc;
    tick();
    deq_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    #3;
    tests++; if (if_a.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", if_a.full); end
    tests++; if (if_a.enq_ready !== 1'b1) begin fails++; $display("FAIL reset_enq_ready: got %b want 1", if_a.enq_ready); end
    tests++; if (if_a.opc_ready !== 4'b0000) begin fails++; $display("FAIL reset_opc_ready: got %b want 0000", if_a.opc_ready); end
    tests++; if (if_a.sel_valid !== 1'b0) begin fails++; $display("FAIL reset_sel_valid: got %b want 0", if_a.sel_valid); end
    tests++; if (if_a.enq_opc !== 2'd0) begin fails++; $display("FAIL reset_enq_opc: got %0d want 0", if_a.enq_opc); end
    tests++; if (if_b.opc_busy !== 4'b0000) begin fails++; $display("FAIL reset_busy_b: got %b want 0000", if_b.opc_busy); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_war();
    do_reset();
    tests++; if (if_a.enq_opc !== 2'd0) begin fails++; $display("FAIL war_opc_a: got %0d want 0", if_a.enq_opc); end
    enq(2'd0, 6'd10, 1'b1, 6'd1, 6'd5, 6'd2, 3'b011, 1'b0, 1'b0);
    tests++; if (if_a.enq_opc !== 2'd1) begin fails++; $display("FAIL war_opc_b: got %0d want 1", if_a.enq_opc); end
    enq(2'd0, 6'd5, 1'b1, 6'd3, 6'd4, 6'd6, 3'b011, 1'b0, 1'b0);
    tests++; if (if_a.opc_wait_mask[1] !== 4'b0001) begin fails++; $display("FAIL war_row_a: got %b want 0001", if_a.opc_wait_mask[1]); end
    tests++; if (if_b.opc_wait_mask[1] !== 4'b0001) begin fails++; $display("FAIL war_row_b: got %b want 0001", if_b.opc_wait_mask[1]); end
    tests++; if (if_a.opc_ready !== 4'b0001) begin fails++; $display("FAIL war_ready: got %b want 0001", if_a.opc_ready); end
    tests++; if (if_a.sel_valid !== 1'b1 || if_a.sel_opc !== 2'd0) begin fails++; $display("FAIL war_sel: got %b/%0d want 1/0", if_a.sel_valid, if_a.sel_opc); end
    deq(2'd0);
    tests++; if (if_a.opc_wait_mask[1] !== 4'b0000) begin fails++; $display("FAIL war_row_clear: got %b want 0000", if_a.opc_wait_mask[1]); end
    tests++; if (if_a.opc_ready !== 4'b0010) begin fails++; $display("FAIL war_ready_after: got %b want 0010", if_a.opc_ready); end
    tests++; if (if_a.opc_busy !== 4'b0010) begin fails++; $display("FAIL war_busy_after: got %b want 0010", if_a.opc_busy); end
    tests++; if (if_a.sel_opc !== 2'd1) begin fails++; $display("FAIL war_sel_after: got %0d want 1", if_a.sel_opc); end
  endtask

  task automatic test_diff_warp();
    do_reset();
    enq(2'd0, 6'd10, 1'b1, 6'd1, 6'd5, 6'd2, 3'b011, 1'b0, 1'b0);
    enq(2'd1, 6'd5, 1'b1, 6'd3, 6'd4, 6'd6, 3'b011, 1'b0, 1'b0);
    tests++; if (if_a.opc_wait_mask[1] !== 4'b0000) begin fails++; $display("FAIL warp_row: got %b want 0000", if_a.opc_wait_mask[1]); end
    tests++; if (if_a.opc_ready !== 4'b0011) begin fails++; $display("FAIL warp_ready: got %b want 0011", if_a.opc_ready); end
    tests++; if (if_a.sel_opc !== 2'd0) begin fails++; $display("FAIL warp_sel: got %0d want 0", if_a.sel_opc); end
    deq(2'd0);
    // slot 0 is refilled but is now younger than slot 1
    enq(2'd2, 6'd20, 1'b1, 6'd21, 6'd22, 6'd23, 3'b000, 1'b0, 1'b0);
    tests++; if (if_a.opc_ready !== 4'b0011) begin fails++; $display("FAIL age_ready: got %b want 0011", if_a.opc_ready); end
    tests++; if (if_a.sel_opc !== 2'd1) begin fails++; $display("FAIL age_sel_a: got %0d want 1", if_a.sel_opc); end
    tests++; if (if_b.sel_opc !== 2'd1) begin fails++; $display("FAIL age_sel_b: got %0d want 1", if_b.sel_opc); end
  endtask

  task automatic test_lsu();
    do_reset();
    enq(2'd0, 6'd7, 1'b1, 6'd8, 6'd0, 6'd0, 3'b001, 1'b1, 1'b0);
    enq(2'd1, 6'd9, 1'b1, 6'd11, 6'd0, 6'd0, 3'b001, 1'b1, 1'b0);
    tests++; if (if_a.opc_wait_mask[1] !== 4'b0001) begin fails++; $display("FAIL lsu_ll_mode1: got %b want 0001", if_a.opc_wait_mask[1]); end
    tests++; if (if_b.opc_wait_mask[1] !== 4'b0000) begin fails++; $display("FAIL lsu_ll_mode2: got %b want 0000", if_b.opc_wait_mask[1]); end
    enq(2'd2, 6'd0, 1'b0, 6'd12, 6'd13, 6'd0, 3'b011, 1'b1, 1'b1);
    tests++; if (if_a.opc_wait_mask[2] !== 4'b0011) begin fails++; $display("FAIL lsu_ls_mode1: got %b want 0011", if_a.opc_wait_mask[2]); end
    tests++; if (if_b.opc_wait_mask[2] !== 4'b0011) begin fails++; $display("FAIL lsu_ls_mode2: got %b want 0011", if_b.opc_wait_mask[2]); end
  endtask

  task automatic test_raw_waw();
    do_reset();
    enq(2'd0, 6'd15, 1'b1, 6'd1, 6'd0, 6'd0, 3'b001, 1'b0, 1'b0);
    enq(2'd0, 6'd16, 1'b1, 6'd15, 6'd0, 6'd0, 3'b001, 1'b0, 1'b0);
    tests++; if (if_a.opc_wait_mask[1] !== 4'b0000) begin fails++; $display("FAIL raw_off: got %b want 0000", if_a.opc_wait_mask[1]); end
    tests++; if (if_b.opc_wait_mask[1] !== 4'b0001) begin fails++; $display("FAIL raw_on: got %b want 0001", if_b.opc_wait_mask[1]); end
    enq(2'd0, 6'd15, 1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 1'b0);
    tests++; if (if_a.opc_wait_mask[2] !== 4'b0011) begin fails++; $display("FAIL waw_war_a: got %b want 0011", if_a.opc_wait_mask[2]); end
    tests++; if (if_b.opc_wait_mask[2] !== 4'b0011) begin fails++; $display("FAIL waw_war_b: got %b want 0011", if_b.opc_wait_mask[2]); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    enq(2'd0, 6'd10, 1'b1, 6'd1, 6'd5, 6'd2, 3'b011, 1'b0, 1'b0);
    set_enq(2'd0, 6'd5, 1'b1, 6'd3, 6'd4, 6'd6, 3'b011, 1'b0, 1'b0);
    deq_valid = 1'b1;
    deq_opc   = 2'd0;
    #1;
    tests++; if (if_a.enq_opc !== 2'd1) begin fails++; $display("FAIL same_enq_opc: got %0d want 1", if_a.enq_opc); end
    tick();
    enq_valid = 1'b0;
    deq_valid = 1'b0;
    tests++; if (if_a.opc_busy !== 4'b0010) begin fails++; $display("FAIL same_busy: got %b want 0010", if_a.opc_busy); end
    tests++; if (if_a.opc_wait_mask[1] !== 4'b0000) begin fails++; $display("FAIL same_row: got %b want 0000", if_a.opc_wait_mask[1]); end
    tests++; if (if_a.sel_valid !== 1'b1 || if_a.sel_opc !== 2'd1) begin fails++; $display("FAIL same_sel: got %b/%0d want 1/1", if_a.sel_valid, if_a.sel_opc); end
    tests++; if (if_a.enq_opc !== 2'd0) begin fails++; $display("FAIL same_realloc: got %0d want 0", if_a.enq_opc); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++)
      enq(2'(i), 6'(30 + i), 1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 1'b0);
    tests++; if (if_a.full !== 1'b1 || if_a.enq_ready !== 1'b0) begin fails++; $display("FAIL full_flag: got %b/%b want 1/0", if_a.full, if_a.enq_ready); end
    enq(2'd0, 6'd30, 1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 1'b0);
    tests++; if (if_a.opc_busy !== 4'b1111) begin fails++; $display("FAIL full_busy: got %b want 1111", if_a.opc_busy); end
    tests++; if (if_a.opc_ready !== 4'b1111) begin fails++; $display("FAIL full_ignored: got %b want 1111", if_a.opc_ready); end
    tests++; if (if_a.sel_opc !== 2'd0) begin fails++; $display("FAIL full_sel: got %0d want 0", if_a.sel_opc); end
    deq(2'd2);
    tests++; if (if_a.enq_opc !== 2'd2) begin fails++; $display("FAIL full_enq_opc: got %0d want 2", if_a.enq_opc); end
    tests++; if (if_a.full !== 1'b0 || if_a.enq_ready !== 1'b1) begin fails++; $display("FAIL full_release: got %b/%b want 0/1", if_a.full, if_a.enq_ready); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      enq(2'(i), 6'(40 + i), 1'b1, 6'd0, 6'd0, 6'd0, 3'b000, 1'b0, 1'b0);
    tests++; if (if_a.opc_busy !== 4'b0111) begin fails++; $display("FAIL areset_pre: got %b want 0111", if_a.opc_busy); end
    reset     = 1'b1;
    deq_valid = 1'b1;
    deq_opc   = 2'd0;
    #2;
    tests++; if (if_a.opc_busy !== 4'b0000) begin fails++; $display("FAIL areset_busy: got %b want 0000", if_a.opc_busy); end
    tests++; if (if_a.sel_valid !== 1'b0) begin fails++; $display("FAIL areset_sel: got %b want 0", if_a.sel_valid); end
    tests++; if (if_b.opc_busy !== 4'b0000) begin fails++; $display("FAIL areset_busy_b: got %b want 0000", if_b.opc_busy); end
    #2;
    reset     = 1'b0;
    deq_valid = 1'b0;
    tick();
    tests++; if (if_a.opc_busy !== 4'b0000 || if_a.enq_opc !== 2'd0) begin fails++; $display("FAIL areset_post: got %b/%0d want 0000/0", if_a.opc_busy, if_a.enq_opc); end
  endtask

  initial begin
    test_reset();
    test_war();
    test_diff_warp();
    test_lsu();
    test_raw_waw();
    test_same_cycle();
    test_full();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
